// File: rtl/mul_div_sched.sv
// Multiply/divide issue scheduler with a shared writeback port.
// Multiplies are fixed-latency and win writeback; a colliding divide result is held.
module mul_div_sched #(
    parameter int WORD_WIDTH = 32,
    parameter int ROB_AW     = 5,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iq_valid,
    input  logic                  iq_is_div,
    input  logic [ROB_AW-1:0]     iq_pdst,
    output logic                  iq_ready,
    input  logic                  flush,
    output logic                  mul_issue,
    input  logic [WORD_WIDTH-1:0] mul_result,
    output logic                  div_issue,
    output logic                  div_kill,
    input  logic                  div_done,
    input  logic [WORD_WIDTH-1:0] div_result,
    output logic                  wb_valid,
    output logic [ROB_AW-1:0]     wb_pdst,
    output logic [WORD_WIDTH-1:0] wb_data,
    output logic                  wb_is_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } div_state_t;

    div_state_t div_state;
    div_state_t div_state_nxt;

    logic [MUL_LAT-1:0] pipe_vld;
    logic [ROB_AW-1:0]  pipe_tag [MUL_LAT];

    logic                  accept;
    logic                  mul_emerge;
    logic                  hold_load;
    logic [ROB_AW-1:0]     div_tag;
    logic [WORD_WIDTH-1:0] hold_data;

    assign mul_emerge = pipe_vld[MUL_LAT-1];

    // Divides need a free divider; multiplies stall only while a divide result waits.
    always_comb begin
        iq_ready = 1'b0;
        if (iq_is_div) begin
            iq_ready = (div_state == IDLE);
        end else begin
            iq_ready = (div_state != HOLD);
        end
    end

    // Handshake; gated by reset so nothing issues while the block is held in reset.
    always_comb begin
        accept    = rst_n && iq_valid && iq_ready && !flush;
        mul_issue = accept && !iq_is_div;
        div_issue = accept && iq_is_div;
        div_kill  = flush && (div_state == BUSY);
    end

    // Multiply tracking pipe: the tag emerges exactly MUL_LAT cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else if (flush) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= mul_issue;
            pipe_tag[0] <= iq_pdst;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    // Divider FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state <= IDLE;
        end else begin
            div_state <= div_state_nxt;
        end
    end

    // Divider FSM next state; a done that collides with a multiply parks in HOLD.
    always_comb begin
        div_state_nxt = div_state;
        hold_load     = 1'b0;
        if (flush) begin
            div_state_nxt = IDLE;
        end else begin
            unique case (div_state)
                IDLE: begin
                    if (div_issue) begin
                        div_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (div_done) begin
                        hold_load     = mul_emerge;
                        div_state_nxt = mul_emerge ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!mul_emerge) begin
                        div_state_nxt = IDLE;
                    end
                end
                default: begin
                    div_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Divide tag and held result; flush drops whatever was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_tag   <= '0;
            hold_data <= '0;
        end else begin
            if (div_issue) begin
                div_tag <= iq_pdst;
            end
            if (flush) begin
                hold_data <= '0;
            end else if (hold_load) begin
                hold_data <= div_result;
            end
        end
    end

    // Writeback mux: multiply first, then held divide, then a fresh divide done.
    always_comb begin
        wb_valid  = 1'b0;
        wb_pdst   = '0;
        wb_data   = '0;
        wb_is_div = 1'b0;
        if (!flush) begin
            if (mul_emerge) begin
                wb_valid = 1'b1;
                wb_pdst  = pipe_tag[MUL_LAT-1];
                wb_data  = mul_result;
            end else if (div_state == HOLD) begin
                wb_valid  = 1'b1;
                wb_pdst   = div_tag;
                wb_data   = hold_data;
                wb_is_div = 1'b1;
            end else if (div_state == BUSY && div_done) begin
                wb_valid  = 1'b1;
                wb_pdst   = div_tag;
                wb_data   = div_result;
                wb_is_div = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_sched.sv
// Bench for mul_div_sched: directed scenarios plus a randomized run
// checked against a transaction-level model of the writeback schedule.
module tb_mul_div_sched;

    localparam int WW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 3;

    logic          clk;
    logic          rst_n;
    logic          iq_valid;
    logic          iq_is_div;
    logic [AW-1:0] iq_pdst;
    logic          iq_ready;
    logic          flush;
    logic          mul_issue;
    logic [WW-1:0] mul_result;
    logic          div_issue;
    logic          div_kill;
    logic          div_done;
    logic [WW-1:0] div_result;
    logic          wb_valid;
    logic [AW-1:0] wb_pdst;
    logic [WW-1:0] wb_data;
    logic          wb_is_div;

    int checks = 0;
    int errors = 0;

    mul_div_sched #(
        .WORD_WIDTH(WW),
        .ROB_AW    (AW),
        .MUL_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iq_valid  (iq_valid),
        .iq_is_div (iq_is_div),
        .iq_pdst   (iq_pdst),
        .iq_ready  (iq_ready),
        .flush     (flush),
        .mul_issue (mul_issue),
        .mul_result(mul_result),
        .div_issue (div_issue),
        .div_kill  (div_kill),
        .div_done  (div_done),
        .div_result(div_result),
        .wb_valid  (wb_valid),
        .wb_pdst   (wb_pdst),
        .wb_data   (wb_data),
        .wb_is_div (wb_is_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        iq_valid   = 1'b0;
        iq_is_div  = 1'b0;
        iq_pdst    = '0;
        flush      = 1'b0;
        div_done   = 1'b0;
        div_result = '0;
        mul_result = '0;
    endtask

    task automatic put_op(input logic d, input logic [AW-1:0] p);
        iq_valid  = 1'b1;
        iq_is_div = d;
        iq_pdst   = p;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        put_op(1'b0, 5'd1);
        #3;
        checks++;
        if (iq_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_mul got=%0b exp=1", iq_ready);
        end
        checks++;
        if (mul_issue !== 1'b0 || div_issue !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue got=%0b%0b exp=00", mul_issue, div_issue);
        end
        iq_is_div = 1'b1;
        div_done  = 1'b1;
        #1;
        checks++;
        if (iq_ready !== 1'b1 || div_issue !== 1'b0) begin
            errors++;
            $display("FAIL rst_div got rdy=%0b iss=%0b exp 1/0", iq_ready, div_issue);
        end
        checks++;
        if (wb_valid !== 1'b0 || wb_pdst !== '0 || wb_data !== '0 || div_kill !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb got v=%0b p=%0h d=%0h k=%0b exp 0", wb_valid, wb_pdst, wb_data, div_kill);
        end
        repeat (2) @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_mul_timing();
        @(negedge clk);
        put_op(1'b0, 5'd5);
        #1;
        checks++;
        if (mul_issue !== 1'b1 || div_issue !== 1'b0) begin
            errors++;
            $display("FAIL mul_issue got=%0b%0b exp=10", mul_issue, div_issue);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            clear_inputs();
            mul_result = 32'hCAFE_0000 + k;
            #1;
            checks++;
            if (k < LAT && wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_early k=%0d got wb_valid=%0b exp=0", k, wb_valid);
            end else if (k == LAT && (wb_valid !== 1'b1 || wb_pdst !== 5'd5 || wb_is_div !== 1'b0 || wb_data !== 32'hCAFE_0003)) begin
                errors++;
                $display("FAIL mul_wb got v=%0b p=%0d div=%0b d=%0h exp 1/5/0/cafe0003", wb_valid, wb_pdst, wb_is_div, wb_data);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_div_latency();
        put_op(1'b1, 5'd7);
        #1;
        checks++;
        if (div_issue !== 1'b1 || mul_issue !== 1'b0) begin
            errors++;
            $display("FAIL div_issue got=%0b%0b exp=10", div_issue, mul_issue);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            put_op(1'b1, 5'd9);
            #1;
            checks++;
            if (iq_ready !== 1'b0 || div_issue !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL div_bp k=%0d got rdy=%0b iss=%0b wb=%0b exp 0/0/0", k, iq_ready, div_issue, wb_valid);
            end
        end
        @(negedge clk);
        clear_inputs();
        div_done   = 1'b1;
        div_result = 32'h1234_5678;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_pdst !== 5'd7 || wb_data !== 32'h1234_5678 || wb_is_div !== 1'b1) begin
            errors++;
            $display("FAIL div_wb got v=%0b p=%0d d=%0h div=%0b exp 1/7/12345678/1", wb_valid, wb_pdst, wb_data, wb_is_div);
        end
        @(negedge clk);
        clear_inputs();
        iq_is_div = 1'b1;
        #1;
        checks++;
        if (iq_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL div_after got rdy=%0b wb=%0b exp 1/0", iq_ready, wb_valid);
        end
        iq_is_div = 1'b0;
    endtask

    // Drive a divide then a multiply so that div_done lands on the emerging multiply.
    task automatic reach_collision(input logic [AW-1:0] dtag, input logic [AW-1:0] mtag,
                                   input logic [WW-1:0] dres, input logic [WW-1:0] mres);
        @(negedge clk);
        put_op(1'b1, dtag);
        @(negedge clk);
        put_op(1'b0, mtag);
        repeat (LAT - 1) begin
            @(negedge clk);
            clear_inputs();
        end
        @(negedge clk);
        div_done   = 1'b1;
        div_result = dres;
        mul_result = mres;
    endtask

    task automatic test_collision();
        reach_collision(5'd11, 5'd3, 32'hD1D1_0001, 32'hAAAA_0003);
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_pdst !== 5'd3 || wb_data !== 32'hAAAA_0003 || wb_is_div !== 1'b0) begin
            errors++;
            $display("FAIL coll_mul got v=%0b p=%0d d=%0h div=%0b exp 1/3/aaaa0003/0", wb_valid, wb_pdst, wb_data, wb_is_div);
        end
        @(negedge clk);
        clear_inputs();
        div_result = 32'hFFFF_FFFF;
        put_op(1'b0, 5'd1);
        #1;
        checks++;
        if (iq_ready !== 1'b0 || mul_issue !== 1'b0) begin
            errors++;
            $display("FAIL coll_hold_rdy got rdy=%0b iss=%0b exp 0/0", iq_ready, mul_issue);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_pdst !== 5'd11 || wb_data !== 32'hD1D1_0001 || wb_is_div !== 1'b1) begin
            errors++;
            $display("FAIL coll_held got v=%0b p=%0d d=%0h div=%0b exp 1/11/d1d10001/1", wb_valid, wb_pdst, wb_data, wb_is_div);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (iq_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL coll_after got rdy=%0b wb=%0b exp 1/0", iq_ready, wb_valid);
        end
    endtask

    task automatic test_flush_busy();
        @(negedge clk);
        put_op(1'b1, 5'd12);
        @(negedge clk);
        put_op(1'b0, 5'd4);
        @(negedge clk);
        put_op(1'b0, 5'd6);
        @(negedge clk);
        put_op(1'b1, 5'd14);
        flush = 1'b1;
        #1;
        checks++;
        if (div_kill !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got k=%0b wb=%0b exp 1/0", div_kill, wb_valid);
        end
        checks++;
        if (mul_issue !== 1'b0 || div_issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue got=%0b%0b exp=00", mul_issue, div_issue);
        end
        @(negedge clk);
        clear_inputs();
        put_op(1'b1, 5'd13);
        #1;
        checks++;
        if (div_kill !== 1'b0 || div_issue !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_next got k=%0b iss=%0b wb=%0b exp 0/1/0", div_kill, div_issue, wb_valid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_mul6 got wb=%0b exp 0", wb_valid);
        end
        @(negedge clk);
        div_done   = 1'b1;
        div_result = 32'h0000_BEEF;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_pdst !== 5'd13 || wb_data !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL flush_redo got v=%0b p=%0d d=%0h exp 1/13/beef", wb_valid, wb_pdst, wb_data);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_flush_accept();
        put_op(1'b0, 5'd21);
        flush = 1'b1;
        #1;
        checks++;
        if (mul_issue !== 1'b0 || div_issue !== 1'b0) begin
            errors++;
            $display("FAIL flacc_issue got=%0b%0b exp=00", mul_issue, div_issue);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL flacc_wb k=%0d got wb=%0b exp 0", k, wb_valid);
            end
        end
    endtask

    task automatic test_reset_hold();
        reach_collision(5'd2, 5'd8, 32'h0000_0D0D, 32'h0000_0808);
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_pdst !== 5'd2) begin
            errors++;
            $display("FAIL rh_pre got v=%0b p=%0d exp 1/2", wb_valid, wb_pdst);
        end
        #1;
        rst_n = 1'b0;
        #1;
        iq_is_div = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || iq_ready !== 1'b1) begin
            errors++;
            $display("FAIL rh_async got wb=%0b rdy=%0b exp 0/1", wb_valid, iq_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        div_done   = 1'b1;
        div_result = 32'h0BAD_0BAD;
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_late got wb=%0b exp 0", wb_valid);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    typedef struct {
        int          due;
        logic [AW-1:0] tag;
    } mul_txn_t;

    task automatic test_random();
        mul_txn_t      mq[$];
        mul_txn_t      t;
        int            cyc;
        int            dev_cnt;
        bit            busy;
        bit            held;
        logic [AW-1:0] dtag;
        logic [WW-1:0] hdata;
        bit            emerg;
        bit            e_rdy;
        bit            e_acc;
        bit            e_kill;
        bit            e_v;
        bit            e_isd;
        logic [AW-1:0] e_p;
        logic [WW-1:0] e_d;
        cyc     = 0;
        dev_cnt = 0;
        busy    = 0;
        held    = 0;
        dtag    = '0;
        hdata   = '0;
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            iq_valid   = ($urandom_range(0, 3) != 0);
            iq_is_div  = ($urandom_range(0, 2) == 0);
            iq_pdst    = AW'($urandom);
            flush      = ($urandom_range(0, 39) == 0);
            mul_result = $urandom;
            div_result = $urandom;
            div_done   = (dev_cnt == 1) || (dev_cnt == 0 && $urandom_range(0, 9) == 0);
            #1;
            emerg  = (mq.size() > 0) && (mq[0].due == cyc);
            e_rdy  = iq_is_div ? (!busy && !held) : !held;
            e_acc  = iq_valid && e_rdy && !flush;
            e_kill = flush && busy;
            e_v    = 0;
            e_isd  = 0;
            e_p    = '0;
            e_d    = '0;
            if (!flush) begin
                if (emerg) begin
                    e_v = 1;
                    e_p = mq[0].tag;
                    e_d = mul_result;
                end else if (held) begin
                    e_v   = 1;
                    e_isd = 1;
                    e_p   = dtag;
                    e_d   = hdata;
                end else if (busy && div_done) begin
                    e_v   = 1;
                    e_isd = 1;
                    e_p   = dtag;
                    e_d   = div_result;
                end
            end
            checks++;
            if (iq_ready !== e_rdy) begin
                errors++;
                $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, iq_ready, e_rdy);
            end
            checks++;
            if (mul_issue !== (e_acc && !iq_is_div) || div_issue !== (e_acc && iq_is_div)) begin
                errors++;
                $display("FAIL rnd_issue cyc=%0d got=%0b%0b exp acc=%0b div=%0b", cyc, mul_issue, div_issue, e_acc, iq_is_div);
            end
            checks++;
            if (div_kill !== e_kill) begin
                errors++;
                $display("FAIL rnd_kill cyc=%0d got=%0b exp=%0b", cyc, div_kill, e_kill);
            end
            checks++;
            if (wb_valid !== e_v || wb_pdst !== e_p || wb_data !== e_d || wb_is_div !== e_isd) begin
                errors++;
                $display("FAIL rnd_wb cyc=%0d got v=%0b p=%0d d=%0h div=%0b exp v=%0b p=%0d d=%0h div=%0b",
                         cyc, wb_valid, wb_pdst, wb_data, wb_is_div, e_v, e_p, e_d, e_isd);
            end
            if (flush) begin
                mq.delete();
                busy    = 0;
                held    = 0;
                dev_cnt = 0;
            end else begin
                if (emerg) void'(mq.pop_front());
                if (held && !emerg) held = 0;
                if (busy && div_done) begin
                    busy = 0;
                    if (emerg) begin
                        held  = 1;
                        hdata = div_result;
                    end
                end
                if (dev_cnt > 0) dev_cnt--;
                if (e_acc && iq_is_div) begin
                    busy    = 1;
                    dtag    = iq_pdst;
                    dev_cnt = $urandom_range(1, 6);
                end
                if (e_acc && !iq_is_div) begin
                    t.due = cyc + LAT;
                    t.tag = iq_pdst;
                    mq.push_back(t);
                end
            end
            cyc++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_div_latency();
        test_collision();
        test_flush_busy();
        test_flush_accept();
        test_reset_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
